serial_tx_framer: RTL and testbench
===================================

// Module: serial_tx_framer
// PURPOSE
//   UART transmit stage directly downstream of message_printer: consumes its tx_data/new_tx_data
//   byte handshake, returns tx_busy, and serialises each accepted byte as an 8N1 frame
//   (start, 8 data LSB-first, stop) on the tx pin. Single clock domain, no FIFO.
//   Exactly one byte is held at a time.
// PARAMETERS
//   CLK_PER_BIT  100  clock cycles per serial bit (50 MHz / 500 kbaud); legal range >= 2
//   STOP_BITS    1    number of stop bits, 1 or 2
//   PARITY_ODD   0    0 = even, 1 = odd parity; used only when SERIAL_TX_PARITY_EN is defined
// PORTS
//   clk          in   1  system clock, all state on rising edge
//   rst          in   1  asynchronous, active-low reset
//   tx_data      in   8  byte to send, sampled only on the accept cycle
//   new_tx_data  in   1  one-cycle request strobe from message_printer
//   block        in   1  flow-control hold from downstream; stalls new frames only
//   tx_busy      out  1  registered; 1 = request will be ignored
//   tx           out  1  serial line, idle high
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, tx=1, tx_busy=0, bit/cycle counters=0, shift reg=0.
//   - Reset mid-frame: frame abandoned, tx returns to 1 immediately, no partial frame resumes.
//   - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept: in IDLE, when new_tx_data=1 and block=0 and tx_busy=0 -> latch tx_data.
//     Next edge: state=START, tx=0, tx_busy=1. Latency request->start bit = 1 clk.
//   - A new_tx_data arriving while tx_busy=1 is dropped silently. No queueing.
//   - Each bit is held for exactly CLK_PER_BIT cycles. The cycle counter is $clog2(CLK_PER_BIT) bits
//     wide and counts 0..CLK_PER_BIT-1, then wraps to 0 and advances the bit.
//   - DATA: the shift register is shifted right and tx = bit0, 8 bits. A 3-bit counter terminates at 7.
//   - STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles. On the final cycle's edge, state=IDLE and tx_busy=0.
//   - Back-to-back: a request in the first IDLE cycle starts the next start bit one cycle later.
//     Minimum inter-frame high time is stop time plus 1 clk.
//   - block: in IDLE, block=1 forces tx_busy=1 on the next edge. The accept condition is gated same cycle.
//     block asserted mid-frame does not abort the frame. tx_busy stays 1 after STOP while block=1.
//   - Frame length (no parity) = (9+STOP_BITS)*CLK_PER_BIT cycles from the start-bit edge.
//   - tx_data changes after accept have no effect on the frame in flight.
// CONFIGURATION
//   SERIAL_TX_PARITY_EN defined:
//   - A PARITY state is inserted between DATA and STOP for CLK_PER_BIT cycles.
//   - tx = ^latched_byte ^ PARITY_ODD.
//   - Frame length = (10+STOP_BITS)*CLK_PER_BIT.
//   SERIAL_TX_PARITY_EN undefined:
//   - The PARITY state and its logic do not exist. PARITY_ODD is ignored.
//   - The frame is pure 8N1/8N2.
// TESTING  (CLK_PER_BIT=4, STOP_BITS=1 unless noted)
//   1. Hold rst=0 for 3 clks, toggle new_tx_data.
//      -> tx=1, tx_busy=0 throughout; release rst -> no activity.
//   2. Pulse new_tx_data with tx_data=8'h55.
//      -> tx_busy=1 next clk.
//      -> tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 clks.
//      -> tx_busy=0 exactly 40 clks after the start bit.
//   3. Send 8'h31 ("1"), re-pulse new_tx_data with 8'h30 at cycle 12 of the frame.
//      -> second request dropped, only one frame carrying 8'h31.
//      Then send "1" and "0" back-to-back on the first IDLE cycle.
//      -> tx_busy low for exactly 1 clk between frames.
//   4. block=1 in IDLE plus new_tx_data with 8'h41.
//      -> no start bit, tx_busy=1 next clk.
//      Drop block -> tx_busy=0 next clk, line stays 1.
//   5. Start 8'hA5, assert rst=0 during data bit 3.
//      -> tx=1 and tx_busy=0 immediately.
//      After release, send 8'h30 -> correct frame 0,0,0,0,0,1,1,0,0,1.
//   6. SERIAL_TX_PARITY_EN, PARITY_ODD=0, send 8'h31 (three 1s).
//      -> parity bit=1, frame 44 clks.
//      STOP_BITS=2 -> stop high 8 clks, tx_busy falls at clk 48.

Source files
------------

// File: rtl/serial_tx_framer.sv
// UART 8N1/8N2 transmit framer: one byte held, start + 8 data LSB-first (+ parity) + stop bits.
// Latency: accept edge drives the start bit; backpressure: tx_busy/block drop requests, no queueing.
// Optional parity bit is enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_framer #(
  parameter int CLK_PER_BIT = 100,
  parameter int STOP_BITS   = 1,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  input  logic       block,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);
  assign tx      = tx_q;
  assign tx_busy = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = block;
        // busy_q also covers the cycle after block drops, so that request is ignored too
        if (new_tx_data && !block && !busy_q) begin
          shift_d = tx_data;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = (^tx_data) ^ PARITY_ODD;
`endif
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        tx_d  = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            busy_d  = block;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer at CLK_PER_BIT=4: frame tables, drop, block, reset, 2 stop bits.
`timescale 1ns/1ps
module tb_serial_tx_framer;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB1 = 9 + PB + 1;
  localparam int F1  = NB1 * CPB;
  localparam int F2  = (9 + PB + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       new_tx_data = 1'b0;
  logic       new_tx_data2 = 1'b0;
  logic       block = 1'b0;
  logic       tx_busy, tx, tx_busy2, tx2;

  serial_tx_framer #(.CLK_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .block(block), .tx_busy(tx_busy), .tx(tx)
  );

  serial_tx_framer #(.CLK_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .new_tx_data(new_tx_data2),
    .block(block), .tx_busy(tx_busy2), .tx(tx2)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  logic sm_tx   [0:63];
  logic sm_busy [0:63];

  typedef struct {
    logic [7:0] d;
    logic [8:0] exp9;     // bit 0 = start bit, bits 8:1 = data LSB first
    logic       exp_par;  // even parity of d
    int         repulse;  // sample index to re-pulse a request, -1 = none
    string      name;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the frame has just ended.
  task automatic run_frame(input logic [7:0] d, input logic [8:0] exp9, input logic exp_par,
                           input int repulse, input string name);
    logic       e;
    logic [3:0] got;
    int         nbusy;
    tx_data     = d;
    new_tx_data = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= F1; k++) begin
      @(negedge clk);
      sm_tx[k]   = tx;
      sm_busy[k] = tx_busy;
      if (k == 0) begin
        new_tx_data = 1'b0;
        tx_data     = ~d;
      end
      if (k == repulse) begin
        new_tx_data = 1'b1;
        tx_data     = 8'h30;
      end
      if (k == repulse + 1) new_tx_data = 1'b0;
    end
    for (int j = 0; j < NB1; j++) begin
      if (j < 9) e = exp9[j];
      else if (PB == 1 && j == 9) e = exp_par;
      else e = 1'b1;
      got = {sm_tx[j*CPB+3], sm_tx[j*CPB+2], sm_tx[j*CPB+1], sm_tx[j*CPB]};
      check($sformatf("%s bit%0d", name, j), {5'd0, got}, {5'd0, {4{e}}});
    end
    nbusy = 0;
    for (int k = 0; k < F1; k++) if (sm_busy[k] !== 1'b1) nbusy++;
    check({name, " busy-held"}, 9'(nbusy), 9'd0);
    check({name, " busy-fall"}, {8'd0, sm_busy[F1]}, 9'd0);
    check({name, " idle-tx"}, {8'd0, sm_tx[F1]}, 9'd1);
  endtask

  initial begin
    int nstop;
    tbl[0] = '{8'h55, 9'h0AA, 1'b0, -1, "h55"};
    tbl[1] = '{8'h31, 9'h062, 1'b1, 12, "h31-drop"};
    tbl[2] = '{8'h31, 9'h062, 1'b1, -1, "h31-b2b"};
    tbl[3] = '{8'h30, 9'h060, 1'b0, -1, "h30-b2b"};
    tbl[4] = '{8'hFF, 9'h1FE, 1'b0, -1, "hFF"};
    tbl[5] = '{8'h00, 9'h000, 1'b0, -1, "h00"};
    tbl[6] = '{8'h80, 9'h100, 1'b1, -1, "h80"};
    tbl[7] = '{8'h01, 9'h002, 1'b1, -1, "h01"};

    // Reset held with request toggling: line stays idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst tx c%0d", i), {8'd0, tx}, 9'd1);
      check($sformatf("rst busy c%0d", i), {8'd0, tx_busy}, 9'd0);
      new_tx_data = ~new_tx_data;
    end
    check("rst tx2", {8'd0, tx2}, 9'd1);
    new_tx_data = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-rst idle c%0d", i), {7'd0, tx_busy, tx}, 9'd1);
    end

    // Table frames; consecutive entries are requested on the first idle cycle.
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].d, tbl[i].exp9, tbl[i].exp_par, tbl[i].repulse, tbl[i].name);

    // block in IDLE gates the request and raises tx_busy.
    block = 1'b1; new_tx_data = 1'b1; tx_data = 8'h41;
    @(negedge clk);
    new_tx_data = 1'b0;
    check("block busy", {8'd0, tx_busy}, 9'd1);
    check("block tx", {8'd0, tx}, 9'd1);
    @(negedge clk);
    check("block tx hold", {8'd0, tx}, 9'd1);
    block = 1'b0;
    @(negedge clk);
    check("unblock busy", {8'd0, tx_busy}, 9'd0);
    check("unblock tx", {8'd0, tx}, 9'd1);
    @(negedge clk);
    check("unblock tx hold", {8'd0, tx}, 9'd1);

    // Reset during data bit 3 of 8'hA5.
    tx_data = 8'hA5; new_tx_data = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 0) new_tx_data = 1'b0;
    end
    check("A5 d3 tx", {8'd0, tx}, 9'd0);
    check("A5 d3 busy", {8'd0, tx_busy}, 9'd1);
    rst = 1'b0;
    #1;
    check("midrst tx", {8'd0, tx}, 9'd1);
    check("midrst busy", {8'd0, tx_busy}, 9'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after midrst idle", {7'd0, tx_busy, tx}, 9'd1);
    run_frame(8'h30, 9'h060, 1'b0, -1, "h30-after-rst");

    // Two stop bits on the second instance.
    tx_data = 8'h31; new_tx_data2 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= F2; k++) begin
      @(negedge clk);
      sm_tx[k]   = tx2;
      sm_busy[k] = tx_busy2;
      if (k == 0) new_tx_data2 = 1'b0;
    end
    check("stop2 start", {8'd0, sm_tx[0]}, 9'd0);
    check("stop2 d0", {8'd0, sm_tx[4]}, 9'd1);
`ifdef SERIAL_TX_PARITY_EN
    check("stop2 parity", {8'd0, sm_tx[36]}, 9'd1);
`endif
    nstop = 0;
    for (int k = (9 + PB) * CPB; k < F2; k++) if (sm_tx[k] === 1'b1) nstop++;
    check("stop2 high cycles", 9'(nstop), 9'(2 * CPB));
    check("stop2 busy last", {8'd0, sm_busy[F2-1]}, 9'd1);
    check("stop2 busy fall", {8'd0, sm_busy[F2]}, 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
